// File: rtl/tdm_demux_4_pkg.sv
// Shared constants and state encoding for the 4-channel TDM demultiplexer.
package tdm_demux_4_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SLOT_W = 2;

    typedef logic [SLOT_W-1:0] slot_t;

    typedef enum logic [1:0] {
        StHunt    = 2'd0,
        StCollect = 2'd1,
        StHold    = 2'd2
    } state_e;

endpackage

// File: rtl/tdm_out_reg.sv
// Output holding register: loads a complete frame, keeps it stable until the
// downstream transfer, clears valid when drained with nothing new to load.
module tdm_out_reg #(
    parameter int unsigned DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DATA_W-1:0]   load_data,
    input  logic                  out_ready,
    output logic [4*DATA_W-1:0]   out_data,
    output logic                  out_valid
);

    logic [4*DATA_W-1:0] data_q;
    logic                valid_q;

    // The caller only asserts load when the register is empty or draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            data_q  <= load_data;
            valid_q <= 1'b1;
        end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;

endmodule

// File: rtl/tdm_demux_4.sv
// Four-channel TDM demultiplexer: frame sync on in_sof, slot collection into
// staging, and hand-off of complete frames to the output register.
module tdm_demux_4
    import tdm_demux_4_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    input  logic                  in_sof,
    output logic                  in_ready,
    output logic [4*DATA_W-1:0]   out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err
);

    state_e              state_q, state_d;
    slot_t               slot_q, slot_d;
    logic [DATA_W-1:0]   stage_q [NUM_CH];
    logic [DATA_W-1:0]   stage_d [NUM_CH];
    logic                err_q, err_d;
    logic                load;
    logic [4*DATA_W-1:0] load_data;
    logic                accept;
    logic                can_load;

    assign in_ready = (state_q != StHold);
    assign accept   = in_valid && in_ready;
    assign can_load = !out_valid || out_ready;

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        stage_d   = stage_q;
        err_d     = 1'b0;
        load      = 1'b0;
        load_data = {stage_q[3], stage_q[2], stage_q[1], stage_q[0]};

        unique case (state_q)
            StHunt: begin
                if (accept && in_sof) begin
                    stage_d[0] = in_data;
                    slot_d     = slot_t'(1);
                    state_d    = StCollect;
                end
            end
            StCollect: begin
                if (accept) begin
                    if (slot_q == slot_t'(0)) begin
                        if (in_sof) begin
                            stage_d[0] = in_data;
                            slot_d     = slot_t'(1);
                        end else begin
                            err_d   = 1'b1;
                            state_d = StHunt;
                        end
                    end else if (in_sof) begin
                        // Early sof: drop the partial frame and resync here.
                        err_d      = 1'b1;
                        stage_d[0] = in_data;
                        slot_d     = slot_t'(1);
                    end else begin
                        stage_d[slot_q] = in_data;
                        if (slot_q == slot_t'(NUM_CH - 1)) begin
                            load_data = {in_data, stage_q[2], stage_q[1], stage_q[0]};
                            slot_d    = slot_t'(0);
                            if (can_load) begin
                                load = 1'b1;
                            end else begin
                                state_d = StHold;
                            end
                        end else begin
                            slot_d = slot_q + slot_t'(1);
                        end
                    end
                end
            end
            StHold: begin
                if (out_valid && out_ready) begin
                    load    = 1'b1;
                    state_d = StCollect;
                    slot_d  = slot_t'(0);
                end
            end
            default: begin
                state_d = StHunt;
                slot_d  = slot_t'(0);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StHunt;
            slot_q  <= slot_t'(0);
            err_q   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            err_q   <= err_d;
            stage_q <= stage_d;
        end
    end

    assign err = err_q;

    tdm_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (load_data),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid)
    );

endmodule

// File: doc/tdm_demux_4.md
# tdm_demux_4

Four-channel time-division demultiplexer: accepts a serial sample stream in which channels 0..3 are interleaved one beat per channel, with a start-of-frame marker on channel 0. It reassembles each complete frame into a parallel 4-sample word. It sits at the receive end of the channel-serialising path, upstream of the per-channel beamformer arithmetic. It is the inverse of the 4:1 selection done at the transmit side.

## Interface
- DATA_W, 16, sample width in bits
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous reset, active low; all state clears immediately on assertion
- in_data  in  DATA_W  serial sample
- in_valid  in  1  in_data valid
- in_sof  in  1  qualifies the beat as channel 0 (start of frame); ignored unless in_valid
- in_ready  out  1  block accepts a beat this cycle; accept = in_valid & in_ready
- out_data  out  4*DATA_W  channel k at bits [k*DATA_W +: DATA_W]
- out_valid  out  1  out_data holds a complete frame
- out_ready  in  1  downstream takes frame; transfer = out_valid & out_ready
- err  out  1  one-cycle pulse on framing error

## Operation
- State machine: HUNT (unsynchronised), COLLECT (slot counter 0..3), HOLD (complete frame staged, output busy).
- HUNT: accepted beat without in_sof is discarded, no err. Accepted beat with in_sof is written to staging slot 0, then COLLECT with slot=1.
- COLLECT, slot 1..3, accepted beat without in_sof: written to staging slot `slot`; slot increments.
- COLLECT, slot 1..3, accepted beat with in_sof: err pulses; partial frame is abandoned; beat is written to slot 0; slot=1.
- COLLECT, slot 0 (synchronised, awaiting next frame):
  - in_sof beat: written to slot 0, slot=1.
  - Non-sof beat: err pulses, beat is discarded, state goes to HUNT.
- Frame completion on the slot-3 write:
  - If output register is empty (!out_valid) or drains this cycle (out_valid & out_ready): staging plus the slot-3 beat load out_data; out_valid=1; COLLECT slot 0.
  - Otherwise the frame stays in staging and state goes to HOLD.
- HOLD: in_ready=0. On out_valid & out_ready, staging loads out_data (out_valid stays 1) and the next state is COLLECT slot 0.
- in_ready = (state != HOLD), decoded from registered state only; no combinational path from out_ready.
- Output register: out_valid clears on transfer when no new frame loads that cycle. out_data and out_valid are held stable while out_valid & !out_ready.
- Samples pass through unmodified; no arithmetic.

## Timing
- Reset values: out_valid=0, out_data=0, err=0, state=HUNT, slot=0, staging=0. in_ready=1 once rst_n deasserts.
- Latency: slot-3 beat accepted at edge N gives out_valid=1 with that frame from N+1.
- Throughput: one beat per cycle sustained; a frame every 4 cycles when out_ready=1.
- err is registered; it is high in the cycle after the offending beat is accepted.
- Simultaneous completion and drain in the same cycle: new frame replaces old with no bubble on out_valid.
- Reset mid-frame or in HOLD: partial and staged data are discarded; return to HUNT; the first post-reset frame must carry in_sof.
- in_valid=0 cycles inside a frame are allowed; slot is held.

## Structure
- Shared package/include holds NUM_CH=4, the slot width (2), and state encodings HUNT/COLLECT/HOLD.
- One sub-module, tdm_out_reg: the output holding register with valid/ready load/drain logic. The FSM, slot counter and staging stay in tdm_demux_4.

## Test plan
- Reset, then stream sof+0x0001, 0x0002, 0x0003, 0x0004 with out_ready=1 -> out_data=0x0004_0003_0002_0001 and out_valid high for 1 cycle, 1 cycle after the 4th beat; err never asserts.
- 3 back-to-back frames with out_ready=1 -> 3 out_valid pulses at 4-cycle spacing; in_ready constantly 1.
- out_ready=0 through 2 full frames -> first frame held on out_data; in_ready drops after the second frame's 4th beat. Raise out_ready for 1 cycle -> second frame appears next cycle, in_ready returns to 1.
- From reset, send 0x00AA, 0x00BB without sof, then a valid frame -> junk discarded, no err, correct frame output.
- Send sof,A,B, then sof,C,D,E,F -> err pulses once; output is F_E_D_C (channel 3 in the MSBs).
- After a good frame, send non-sof 0x1234 at slot 0 -> err pulses once and the beat is dropped. Next sof frame outputs correctly.
- Assert rst_n low after 2 beats of a frame -> out_valid=0 immediately. A following complete frame outputs correctly with no leftover samples.
